// File: rtl/pixel_writer.sv
// Pixel FIFO feeding a framebuffer write port, plus a full-screen clear sweep.
// First write presented one edge after enqueue; in_ready drops at DEPTH pending pixels, mem_ready stalls drain and sweep.
module pixel_writer #(
    parameter int DEPTH = 4,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [2:0]  colour,
    input  logic        writeEn,
    output logic        in_ready,
    input  logic        clear,
    input  logic [2:0]  clear_colour,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        busy,
    output logic        overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [14:0] LAST_ADDR = 15'(SCR_W * SCR_H - 1);
    localparam logic [9:0]  W10 = 10'(SCR_W);
    localparam logic [9:0]  H10 = 10'(SCR_H);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t        state_q;
    logic [14:0]   fifo_addr_q [DEPTH];
    logic [2:0]    fifo_col_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [14:0]   mem_addr_q;
    logic [2:0]    mem_data_q;
    logic          mem_we_q;
    logic [14:0]   sweep_q;
    logic          clr_pend_q;
    logic [2:0]    pend_col_q;
    logic          overflow_q;

    logic        in_range, push, pop, free, fifo_ne, clr_req;
    logic [14:0] lin_addr;

    assign fifo_ne  = (count_q != '0);
    assign in_ready = (count_q != CW'(DEPTH));
    assign in_range = (x < W10) && (y < H10);
    assign lin_addr = 15'(20'(y) * 20'(SCR_W) + 20'(x));
    assign push     = writeEn && in_ready && in_range;
    assign free     = !mem_we_q || mem_ready;
    assign clr_req  = clear || clr_pend_q;

    // Pixels stay queued until memory can take them, so in_ready reflects the whole backlog.
    always_comb begin
        pop = 1'b0;
        if (fifo_ne && mem_ready) begin
            if (state_q == IDLE)
                pop = !clear;
            else if (state_q == DRAIN)
                pop = !clr_req;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= lin_addr;
            fifo_col_q[wr_ptr_q]  <= colour;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            sweep_q    <= '0;
            clr_pend_q <= 1'b0;
            pend_col_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (writeEn && !in_ready && in_range)
                overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q    <= CLEAR;
                        sweep_q    <= '0;
                        mem_addr_q <= '0;
                        mem_data_q <= clear_colour;
                        mem_we_q   <= 1'b1;
                    end else if (pop) begin
                        state_q    <= DRAIN;
                        mem_addr_q <= fifo_addr_q[rd_ptr_q];
                        mem_data_q <= fifo_col_q[rd_ptr_q];
                        mem_we_q   <= 1'b1;
                    end else if (fifo_ne) begin
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (free) begin
                        if (clr_req) begin
                            state_q    <= CLEAR;
                            clr_pend_q <= 1'b0;
                            sweep_q    <= '0;
                            mem_addr_q <= '0;
                            mem_data_q <= clear ? clear_colour : pend_col_q;
                            mem_we_q   <= 1'b1;
                        end else if (pop) begin
                            mem_addr_q <= fifo_addr_q[rd_ptr_q];
                            mem_data_q <= fifo_col_q[rd_ptr_q];
                            mem_we_q   <= 1'b1;
                        end else begin
                            mem_we_q <= 1'b0;
                            if (!fifo_ne)
                                state_q <= IDLE;
                        end
                    end else if (clear) begin
                        // Held until the stalled write retires so a one-cycle clear is not lost.
                        clr_pend_q <= 1'b1;
                        pend_col_q <= clear_colour;
                    end
                end
                CLEAR: begin
                    if (mem_ready) begin
                        if (sweep_q == LAST_ADDR) begin
                            mem_we_q <= 1'b0;
                            state_q  <= fifo_ne ? DRAIN : IDLE;
                        end else begin
                            sweep_q    <= sweep_q + 15'd1;
                            mem_addr_q <= sweep_q + 15'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || fifo_ne || mem_we_q;
endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: single pixel, backpressure/overflow, range discard, clear sweep, reset abort.
module tb_pixel_writer;
    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  x, y;
    logic [2:0]  colour, clear_colour;
    logic        writeEn, clear, mem_ready;
    logic        in_ready, mem_we, busy, overflow;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;

    int n_cmp = 0;
    int n_err = 0;
    int wa[$];
    int wd[$];

    pixel_writer dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour),
        .writeEn(writeEn), .in_ready(in_ready), .clear(clear),
        .clear_colour(clear_colour), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_ready(mem_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn && mem_we && mem_ready) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_data));
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; writeEn = 1'b0; clear = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        wa.delete(); wd.delete();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, int'(busy), 0);
    endtask

    task automatic check_sweep(input string tag, input int col);
        int bad = 0;
        for (int i = 0; i < 19200; i++) begin
            if (i >= wa.size()) bad++;
            else if (wa[i] != i || wd[i] != col) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        resetn = 1'b0; x = '0; y = '0; colour = '0; writeEn = 1'b0;
        clear = 1'b0; clear_colour = '0; mem_ready = 1'b1;
        tick();
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_data", int'(mem_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy", int'(in_ready), 1);
        tick();
        resetn = 1'b1;

        // single pixel (5,2) -> addr 325
        x = 10'd5; y = 10'd2; colour = 3'b100; writeEn = 1'b1;
        tick();
        writeEn = 1'b0;
        chk("px_we_k", int'(mem_we), 0);
        tick();
        chk("px_we_k1", int'(mem_we), 1);
        chk("px_addr", int'(mem_addr), 325);
        chk("px_data", int'(mem_data), 4);
        tick();
        chk("px_we_k2", int'(mem_we), 0);
        chk("px_busy", int'(busy), 0);
        chk("px_nwr", wa.size(), 1);

        // five pixels while memory stalls
        wa.delete(); wd.delete();
        mem_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            x = 10'(i); y = 10'd0; colour = 3'(i); writeEn = 1'b1;
            tick();
            chk($sformatf("bp_rdy%0d", i), int'(in_ready), (i < 4) ? 1 : 0);
            chk($sformatf("bp_ovf%0d", i), int'(overflow), (i == 5) ? 1 : 0);
        end
        writeEn = 1'b0;
        chk("bp_nwr_stall", wa.size(), 0);
        mem_ready = 1'b1;
        wait_idle(50, "bp_idle");
        chk("bp_nwr", wa.size(), 4);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chk($sformatf("bp_addr%0d", i), wa[i], i + 1);
            chk($sformatf("bp_data%0d", i), wd[i], i + 1);
        end

        // out-of-range pixels
        do_reset();
        x = 10'd160; y = 10'd0; colour = 3'd7; writeEn = 1'b1;
        tick();
        x = 10'd0; y = 10'd120;
        tick();
        writeEn = 1'b0;
        tick(); tick(); tick();
        chk("oor_nwr", wa.size(), 0);
        chk("oor_ovf", int'(overflow), 0);
        chk("oor_busy", int'(busy), 0);
        chk("oor_rdy", int'(in_ready), 1);

        // full clear with colour 0
        clear = 1'b1; clear_colour = 3'd0;
        tick();
        clear = 1'b0;
        chk("clr_we", int'(mem_we), 1);
        wait_idle(20000, "clr_idle");
        chk("clr_nwr", wa.size(), 19200);
        check_sweep("clr_seq", 0);

        // clear with a pixel and a second clear arriving mid-sweep
        wa.delete(); wd.delete();
        clear = 1'b1; clear_colour = 3'd5;
        tick();
        clear = 1'b0;
        repeat (100) tick();
        x = 10'd7; y = 10'd3; colour = 3'd6; writeEn = 1'b1;
        tick();
        writeEn = 1'b0;
        repeat (100) tick();
        clear = 1'b1; clear_colour = 3'd2;
        tick();
        clear = 1'b0;
        wait_idle(20000, "clr2_idle");
        chk("clr2_nwr", wa.size(), 19201);
        check_sweep("clr2_seq", 5);
        if (wa.size() == 19201) begin
            chk("clr2_px_addr", wa[19200], 487);
            chk("clr2_px_data", wd[19200], 6);
        end

        // reset mid-clear with mem_ready toggling and a full FIFO
        clear = 1'b1; clear_colour = 3'd3;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mem_ready = i[0];
            writeEn = (i >= 5 && i < 10);
            x = 10'(i); y = 10'd1; colour = 3'd1;
            tick();
        end
        writeEn = 1'b0;
        chk("ra_we_before", int'(mem_we), 1);
        chk("ra_ovf_before", int'(overflow), 1);
        #3;
        resetn = 1'b0;
        #1;
        chk("ra_we", int'(mem_we), 0);
        chk("ra_addr", int'(mem_addr), 0);
        chk("ra_busy", int'(busy), 0);
        chk("ra_rdy", int'(in_ready), 1);
        chk("ra_ovf", int'(overflow), 0);
        tick();
        resetn = 1'b1;
        mem_ready = 1'b1;
        wa.delete(); wd.delete();
        repeat (10) tick();
        chk("ra_nwr", wa.size(), 0);
        chk("ra_busy_after", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
